// File: rtl/clarvi_mem_pkg.sv
// Shared types for the clarvi data-memory arbiter: read-return owner and
// arbiter FSM state encodings.
package clarvi_mem_pkg;

   localparam int MEM_DATA_WIDTH = 16;

   // Who receives the read data returning in the next cycle.
   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_CPU  = 2'd1,
      OWNER_DMA  = 2'd2
   } owner_t;

   // ARB_LOCKED keeps the port reserved for the CPU between the parts of a
   // multi-part access.
   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/clarvi_rr_arbiter2.sv
// Two-requester round-robin arbiter. Requester 0 is the CPU, requester 1 the
// DMA port. force_grant0 reserves the grant for requester 0 (lock).
module clarvi_rr_arbiter2 (
   input  logic clock,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic force_grant0,
   output logic grant0,
   output logic grant1
);

   // 0 = requester 0 was granted last, 1 = requester 1 was granted last.
   logic last_grant_q;
   logic last_grant_d;

   // Grant selection: forced, tie broken against the last winner, or single.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (force_grant0) begin
         grant0 = req0;
      end else if (req0 && req1) begin
         grant0 = last_grant_q;
         grant1 = !last_grant_q;
      end else begin
         grant0 = req0;
         grant1 = req1;
      end
   end

   // The last winner moves on every grant and holds otherwise.
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant0) begin
         last_grant_d = 1'b0;
      end else if (grant1) begin
         last_grant_d = 1'b1;
      end
   end

   // Reset to "requester 1 last" so the CPU wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/clarvi_mem_arbiter.sv
// Shares the 16-bit data RAM port between the CPU memory unit and a DMA/debug
// requester. Grants are combinational; a locked CPU sequence keeps the port;
// read data returns one cycle later to whichever side issued the read.
//
// Handshake: the CPU presents cpu_read_enable/cpu_write_enable and holds the
// request stable while cpu_wait is high; it is accepted in any cycle where
// the request is high and cpu_wait is low. The DMA side presents dma_req and
// may change it only after a cycle with dma_ready high, which marks
// acceptance. Read data for an accepted read is presented with a one-cycle
// *_read_valid pulse in the following cycle.
module clarvi_mem_arbiter
   import clarvi_mem_pkg::*;
#(
   parameter int DATA_ADDR_WIDTH = 14
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [DATA_ADDR_WIDTH-1:0] cpu_address,
   input  logic [1:0]                 cpu_byte_enable,
   input  logic                       cpu_read_enable,
   input  logic                       cpu_write_enable,
   input  logic [15:0]                cpu_write_data,
   input  logic                       cpu_lock,
   output logic                       cpu_wait,
   output logic [15:0]                cpu_read_data,
   output logic                       cpu_read_valid,
   input  logic                       dma_req,
   input  logic                       dma_write,
   input  logic [DATA_ADDR_WIDTH-1:0] dma_address,
   input  logic [1:0]                 dma_byte_enable,
   input  logic [15:0]                dma_write_data,
   output logic                       dma_ready,
   output logic [15:0]                dma_read_data,
   output logic                       dma_read_valid,
   output logic [DATA_ADDR_WIDTH-1:0] mem_address,
   output logic [1:0]                 mem_byte_enable,
   output logic                       mem_read_enable,
   output logic                       mem_write_enable,
   output logic [15:0]                mem_write_data,
   input  logic [15:0]                mem_read_data
);

   arb_state_t state_q;
   arb_state_t state_d;
   owner_t     read_owner_q;
   owner_t     read_owner_d;

   logic cpu_req;
   logic cpu_granted;
   logic dma_granted;

   assign cpu_req = cpu_read_enable | cpu_write_enable;

   clarvi_rr_arbiter2 u_rr (
      .clock        (clock),
      .reset        (reset),
      .req0         (cpu_req),
      .req1         (dma_req),
      .force_grant0 (state_q == ARB_LOCKED),
      .grant0       (cpu_granted),
      .grant1       (dma_granted)
   );

   // Drive the RAM from the granted requester; strobes only when granted.
   always_comb begin
      mem_address      = cpu_address;
      mem_byte_enable  = cpu_byte_enable;
      mem_write_data   = cpu_write_data;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      if (dma_granted) begin
         mem_address      = dma_address;
         mem_byte_enable  = dma_byte_enable;
         mem_write_data   = dma_write_data;
         mem_read_enable  = !dma_write;
         mem_write_enable = dma_write;
      end else if (cpu_granted) begin
         mem_read_enable  = cpu_read_enable;
         mem_write_enable = cpu_write_enable;
      end
   end

   // Handshake outputs to both requesters.
   always_comb begin
      cpu_wait  = cpu_req & !cpu_granted;
      dma_ready = dma_req & dma_granted;
   end

   // Lock FSM: only a CPU grant moves it; cpu_lock picks the next state.
   always_comb begin
      state_d = state_q;
      if (cpu_granted) begin
         state_d = cpu_lock ? ARB_LOCKED : ARB_IDLE;
      end
   end

   // Remember who owns the read data returning next cycle; writes and idle
   // cycles clear it so each valid is a single-cycle pulse.
   always_comb begin
      read_owner_d = OWNER_NONE;
      if (cpu_granted && cpu_read_enable) begin
         read_owner_d = OWNER_CPU;
      end else if (dma_granted && !dma_write) begin
         read_owner_d = OWNER_DMA;
      end
   end

   // State and read-owner registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ARB_IDLE;
         read_owner_q <= OWNER_NONE;
      end else begin
         state_q      <= state_d;
         read_owner_q <= read_owner_d;
      end
   end

   // Read return; reset also masks a valid that would land in the reset cycle.
   always_comb begin
      cpu_read_data  = mem_read_data;
      dma_read_data  = mem_read_data;
      cpu_read_valid = (read_owner_q == OWNER_CPU) && !reset;
      dma_read_valid = (read_owner_q == OWNER_DMA) && !reset;
   end

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed bench for clarvi_mem_arbiter with a per-cycle bus scoreboard and
// a read-return scoreboard checked by an independent monitor.
module tb_clarvi_mem_arbiter;
   import clarvi_mem_pkg::*;

   localparam int AW    = 14;
   localparam int BUS_W = 38;
   localparam int RD_W  = 50;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] cpu_address;
   logic [1:0]    cpu_byte_enable;
   logic          cpu_read_enable;
   logic          cpu_write_enable;
   logic [15:0]   cpu_write_data;
   logic          cpu_lock;
   logic          cpu_wait;
   logic [15:0]   cpu_read_data;
   logic          cpu_read_valid;
   logic          dma_req;
   logic          dma_write;
   logic [AW-1:0] dma_address;
   logic [1:0]    dma_byte_enable;
   logic [15:0]   dma_write_data;
   logic          dma_ready;
   logic [15:0]   dma_read_data;
   logic          dma_read_valid;
   logic [AW-1:0] mem_address;
   logic [1:0]    mem_byte_enable;
   logic          mem_read_enable;
   logic          mem_write_enable;
   logic [15:0]   mem_write_data;
   logic [15:0]   mem_read_data = 16'h0000;

   int unsigned   cyc_cnt = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   // Expected per-cycle bus view:
   // {state, cpu_wait, dma_ready, re, we, addr[13:0], be[1:0], wdata[15:0], dchk}
   logic [BUS_W-1:0] bus_exp_q[$];
   // Expected read returns: {owner[1:0], data[15:0], cycle[31:0]}
   logic [RD_W-1:0]  rd_exp_q[$];

   clarvi_mem_arbiter #(.DATA_ADDR_WIDTH(AW)) dut (
      .clock            (clock),
      .reset            (reset),
      .cpu_address      (cpu_address),
      .cpu_byte_enable  (cpu_byte_enable),
      .cpu_read_enable  (cpu_read_enable),
      .cpu_write_enable (cpu_write_enable),
      .cpu_write_data   (cpu_write_data),
      .cpu_lock         (cpu_lock),
      .cpu_wait         (cpu_wait),
      .cpu_read_data    (cpu_read_data),
      .cpu_read_valid   (cpu_read_valid),
      .dma_req          (dma_req),
      .dma_write        (dma_write),
      .dma_address      (dma_address),
      .dma_byte_enable  (dma_byte_enable),
      .dma_write_data   (dma_write_data),
      .dma_ready        (dma_ready),
      .dma_read_data    (dma_read_data),
      .dma_read_valid   (dma_read_valid),
      .mem_address      (mem_address),
      .mem_byte_enable  (mem_byte_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

   // Small fixed-content RAM with one-cycle read latency.
   function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
      case (a)
         14'h0010: ram_word = 16'hBEEF;
         14'h0020: ram_word = 16'hCAFE;
         14'h0030: ram_word = 16'h1234;
         default:  ram_word = 16'h0000;
      endcase
   endfunction

   always @(posedge clock) begin
      if (mem_read_enable) mem_read_data <= ram_word(mem_address);
   end

   // ---------------- checking helper ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc_cnt, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      logic [BUS_W-1:0] e;
      logic [RD_W-1:0]  r;
      if (bus_exp_q.size() > 0) begin
         e = bus_exp_q.pop_front();
         check("state",     64'(dut.state_q),   64'(e[37]));
         check("cpu_wait",  64'(cpu_wait),      64'(e[36]));
         check("dma_ready", 64'(dma_ready),     64'(e[35]));
         check("mem_re",    64'(mem_read_enable),  64'(e[34]));
         check("mem_we",    64'(mem_write_enable), 64'(e[33]));
         if (e[0]) begin
            check("mem_addr",  64'(mem_address),     64'(e[32:19]));
            check("mem_be",    64'(mem_byte_enable), 64'(e[18:17]));
            check("mem_wdata", 64'(mem_write_data),  64'(e[16:1]));
         end
      end
      if (cpu_read_valid || dma_read_valid) begin
         check("single_valid", 64'(cpu_read_valid && dma_read_valid), 64'd0);
         if (rd_exp_q.size() == 0) begin
            check("unexpected_valid", {62'd0, dma_read_valid, cpu_read_valid}, 64'd0);
         end else begin
            r = rd_exp_q.pop_front();
            check("rd_owner", {62'd0, dma_read_valid, cpu_read_valid}, 64'(r[49:48]));
            check("rd_data", 64'(cpu_read_valid ? cpu_read_data : dma_read_data), 64'(r[47:32]));
            check("rd_cycle", 64'(cyc_cnt), 64'(r[31:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      cpu_address      = '0;
      cpu_byte_enable  = 2'b11;
      cpu_read_enable  = 1'b0;
      cpu_write_enable = 1'b0;
      cpu_write_data   = 16'h0000;
      cpu_lock         = 1'b0;
      dma_req          = 1'b0;
      dma_write        = 1'b0;
      dma_address      = '0;
      dma_byte_enable  = 2'b11;
      dma_write_data   = 16'h0000;
   endtask

   task automatic cpu_drive(input logic re, input logic we, input logic [AW-1:0] a,
                            input logic [15:0] wd, input logic lock);
      cpu_read_enable  = re;
      cpu_write_enable = we;
      cpu_address      = a;
      cpu_write_data   = wd;
      cpu_byte_enable  = 2'b11;
      cpu_lock         = lock;
   endtask

   task automatic dma_drive(input logic req, input logic wr, input logic [AW-1:0] a,
                            input logic [1:0] be, input logic [15:0] wd);
      dma_req         = req;
      dma_write       = wr;
      dma_address     = a;
      dma_byte_enable = be;
      dma_write_data  = wd;
   endtask

   // Queue the expected view of the current cycle, then advance one cycle.
   task automatic step(input logic st, input logic w, input logic rdy,
                       input logic re, input logic we, input logic [AW-1:0] a,
                       input logic [1:0] be, input logic [15:0] wd, input logic dchk,
                       input logic [1:0] rd_own, input logic [15:0] rd_data);
      bus_exp_q.push_back({st, w, rdy, re, we, a, be, wd, dchk});
      if (rd_own != 2'd0) rd_exp_q.push_back({rd_own, rd_data, cyc_cnt + 32'd1});
      @(posedge clock);
      #1;
   endtask

   task automatic step_idle(input logic st);
      step(st, 1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0, 1'b0, 2'd0, 16'h0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state: idle, no strobes, no handshakes.
      step_idle(1'b0);

      // Tie after reset: CPU read wins, DMA write waits, then goes.
      cpu_drive(1'b1, 1'b0, 14'h0020, 16'h0000, 1'b0);
      dma_drive(1'b1, 1'b1, 14'h0100, 2'b01, 16'hA5A5);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0020, 2'b11, 16'h0000, 1'b1, 2'd1, 16'hCAFE);
      cpu_drive(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0100, 2'b01, 16'hA5A5, 1'b1, 2'd0, 16'h0);
      idle_inputs();
      step_idle(1'b0);

      // Lone CPU read of 0x0010 returns 0xBEEF next cycle.
      cpu_drive(1'b1, 1'b0, 14'h0010, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0010, 2'b11, 16'h0000, 1'b1, 2'd1, 16'hBEEF);
      idle_inputs();
      step_idle(1'b0);

      // Both requesting continuously, CPU won last: DMA, CPU, DMA, CPU.
      cpu_drive(1'b0, 1'b1, 14'h0200, 16'h1111, 1'b0);
      dma_drive(1'b1, 1'b0, 14'h0030, 2'b11, 16'h0000);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 14'h0030, 2'b11, 16'h0000, 1'b1, 2'd2, 16'h1234);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0200, 2'b11, 16'h1111, 1'b1, 2'd0, 16'h0);
      end
      idle_inputs();
      step_idle(1'b0);

      // Lone DMA write so the DMA holds last_grant.
      dma_drive(1'b1, 1'b1, 14'h0040, 2'b11, 16'h7777);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0040, 2'b11, 16'h7777, 1'b1, 2'd0, 16'h0);

      // Locked 4-part CPU write with a DMA read pending throughout.
      dma_drive(1'b1, 1'b0, 14'h0030, 2'b11, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         cpu_drive(1'b0, 1'b1, 14'(14'h0300 + i), 16'(i + 1), (i != 3));
         step((i != 0), 1'b0, 1'b0, 1'b0, 1'b1, 14'(14'h0300 + i), 2'b11, 16'(i + 1),
              1'b1, 2'd0, 16'h0);
      end
      cpu_drive(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0030, 2'b11, 16'h0000, 1'b1, 2'd2, 16'h1234);
      idle_inputs();
      step_idle(1'b0);

      // Lock held across a two-cycle CPU gap; DMA stays blocked.
      cpu_drive(1'b0, 1'b1, 14'h0400, 16'h00AA, 1'b1);
      dma_drive(1'b1, 1'b1, 14'h0050, 2'b11, 16'hBBBB);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0400, 2'b11, 16'h00AA, 1'b1, 2'd0, 16'h0);
      cpu_drive(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b1);
      step_idle(1'b1);
      step_idle(1'b1);
      cpu_drive(1'b0, 1'b1, 14'h0401, 16'h00AB, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0401, 2'b11, 16'h00AB, 1'b1, 2'd0, 16'h0);
      cpu_drive(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0050, 2'b11, 16'hBBBB, 1'b1, 2'd0, 16'h0);
      idle_inputs();

      // Reset mid-lock: back to idle and the CPU wins the next tie again.
      cpu_drive(1'b0, 1'b1, 14'h0500, 16'h00CC, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0500, 2'b11, 16'h00CC, 1'b1, 2'd0, 16'h0);
      idle_inputs();
      reset = 1'b1;
      step_idle(1'b1);
      reset = 1'b0;
      cpu_drive(1'b0, 1'b1, 14'h0600, 16'h00DD, 1'b0);
      dma_drive(1'b1, 1'b1, 14'h0060, 2'b11, 16'h00EE);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 14'h0600, 2'b11, 16'h00DD, 1'b1, 2'd0, 16'h0);
      cpu_drive(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0060, 2'b11, 16'h00EE, 1'b1, 2'd0, 16'h0);
      idle_inputs();

      // DMA read then reset next cycle: its read_valid must not appear.
      dma_drive(1'b1, 1'b0, 14'h0020, 2'b11, 16'h0000);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0020, 2'b11, 16'h0000, 1'b1, 2'd0, 16'h0);
      idle_inputs();
      reset = 1'b1;
      step_idle(1'b0);
      reset = 1'b0;

      // Tie of two reads after reset: CPU then DMA, back-to-back returns.
      cpu_drive(1'b1, 1'b0, 14'h0010, 16'h0000, 1'b0);
      dma_drive(1'b1, 1'b0, 14'h0020, 2'b11, 16'h0000);
      step(1'b0, 1'b1 ^ 1'b1, 1'b0, 1'b1, 1'b0, 14'h0010, 2'b11, 16'h0000, 1'b1, 2'd1, 16'hBEEF);
      cpu_drive(1'b0, 1'b0, 14'h0000, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0020, 2'b11, 16'h0000, 1'b1, 2'd2, 16'hCAFE);
      idle_inputs();
      step_idle(1'b0);
      step_idle(1'b0);

      // Every expected read return must have been seen.
      check("rd_queue_drained", 64'(rd_exp_q.size()), 64'd0);
      check("bus_queue_drained", 64'(bus_exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard stop so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_cnt);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/clarvi_mem_arbiter.md
# clarvi_mem_arbiter

Shares the single 16-bit data memory port between the CPU's memory unit and a secondary DMA/debug requester. Sits between the memory unit's data port and the data RAM, arbitrates per cycle with round-robin fairness, and holds the port for the CPU across a locked multi-part (64-bit) access sequence. Routes the fixed one-cycle-latency read data back to whichever requester issued the read.

## Interface
- DATA_ADDR_WIDTH, 14, data RAM word-address width
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_address  in  DATA_ADDR_WIDTH  CPU word address
- cpu_byte_enable  in  2  CPU byte lanes
- cpu_read_enable  in  1  CPU read request
- cpu_write_enable  in  1  CPU write request
- cpu_write_data  in  16  CPU store data
- cpu_lock  in  1  CPU access is not the last part of a sequence; keep port
- cpu_wait  out  1  CPU request not accepted this cycle; hold request
- cpu_read_data  out  16  read data to CPU
- cpu_read_valid  out  1  cpu_read_data valid
- dma_req  in  1  DMA request valid
- dma_write  in  1  1 = write, 0 = read
- dma_address  in  DATA_ADDR_WIDTH  DMA word address
- dma_byte_enable  in  2  DMA byte lanes
- dma_write_data  in  16  DMA store data
- dma_ready  out  1  DMA request accepted this cycle
- dma_read_data  out  16  read data to DMA
- dma_read_valid  out  1  dma_read_data valid
- mem_address  out  DATA_ADDR_WIDTH  RAM address
- mem_byte_enable  out  2  RAM byte lanes
- mem_read_enable  out  1  RAM read strobe
- mem_write_enable  out  1  RAM write strobe
- mem_write_data  out  16  RAM write data
- mem_read_data  in  16  RAM read data, valid one cycle after mem_read_enable

## Operation
- cpu_req = cpu_read_enable | cpu_write_enable. Both enables high together is illegal.
- States: ARB_IDLE, ARB_LOCKED. Register last_grant (CPU/DMA).
- ARB_IDLE grant:
  - Only one requester: grant it.
  - Both requesting: grant the one not equal to last_grant.
  - None: no grant, all mem strobes 0.
- ARB_LOCKED: CPU always granted when cpu_req; dma_ready = 0.
- Transitions, on a CPU grant:
  - cpu_lock=1 → ARB_LOCKED.
  - cpu_lock=0 → ARB_IDLE.
- ARB_LOCKED with no cpu_req holds state; no grant.
- last_grant updates on every grant.
- Granted requester's address, byte enable and write data drive mem_*.
- mem_read_enable/mem_write_enable come from the granted request only.
- Ungranted mem_* data/address: don't-care. Strobes: 0.
- cpu_wait = cpu_req & !cpu_granted.
- dma_ready = dma_req & dma_granted.
- CPU holds its request stable while cpu_wait is high.
- DMA request may change only after dma_ready.
- Read return:
  - Register read_owner (NONE/CPU/DMA) at each granted read.
  - Next cycle, pulse the owner's *_read_valid for one cycle.
  - Both *_read_data outputs = mem_read_data combinationally.
  - Writes set read_owner = NONE.

## Timing
- Grant, cpu_wait, dma_ready and mem_* are combinational from inputs and state; zero added latency.
- Read latency: request cycle N, *_read_valid in cycle N+1.
- Back-to-back reads from alternating owners are supported every cycle.
- Reset values:
  - state = ARB_IDLE
  - last_grant = DMA, so the CPU wins the first tie
  - read_owner = NONE
  - cpu_read_valid = dma_read_valid = 0
- Reset during an issued read suppresses the following read_valid.
- Reset mid-lock returns to ARB_IDLE.
- A simultaneous CPU request and DMA request in ARB_LOCKED always go to the CPU; dma_req stays pending.

## Structure
- Shared package (clarvi_mem_pkg):
  - owner_t enum: OWNER_NONE, OWNER_CPU, OWNER_DMA
  - arb_state_t enum: ARB_IDLE, ARB_LOCKED
- Sub-module clarvi_rr_arbiter2:
  - Two-requester round-robin grant with last_grant register.
  - Plus a force_grant0 input for the lock.
- Top level holds the FSM, muxes and read_owner tracking.

## Test plan
- CPU read only, addr 0x0010: mem_read_enable=1, cpu_wait=0 in cycle N. Cycle N+1: mem_read_data=0xBEEF gives cpu_read_valid=1, cpu_read_data=0xBEEF, dma_read_valid=0.
- Simultaneous CPU read and DMA write after reset: CPU granted first, dma_ready=0. Next cycle the CPU request drops, DMA still waiting: DMA granted, mem_write_data = dma_write_data.
- Both continuously requesting, unlocked: grants alternate CPU, DMA, CPU, DMA. cpu_wait is high exactly on DMA cycles.
- CPU 4-part write with cpu_lock=1,1,1,0 and dma_req held high throughout: four consecutive CPU writes, dma_ready=0 for all four. DMA granted in the fifth cycle.
- Lock held with a CPU idle gap: cpu_lock=1 access, then cpu_req=0 for 2 cycles with dma_req=1. dma_ready stays 0 and the state stays ARB_LOCKED until the final cpu_lock=0 access.
- DMA read issued, then reset asserted the next cycle: dma_read_valid=0, state ARB_IDLE, CPU wins the next tie.
